// File: rtl/frame_serializer_if.sv
// Byte-in / serial-out bundle for frame_serializer: producer handshake plus frame status.
// The DUT takes the slave view; the producer/observer takes the master view.
interface frame_serializer_if;
    logic [7:0] din_byte;
    logic       din_valid;
    logic       din_ready;
    logic       dout;
    logic       frame_active;
    logic       frame_done;
    logic [7:0] underrun_cnt;

    modport slave (
        input  din_byte,
        input  din_valid,
        output din_ready,
        output dout,
        output frame_active,
        output frame_done,
        output underrun_cnt
    );

    modport master (
        output din_byte,
        output din_valid,
        input  din_ready,
        input  dout,
        input  frame_active,
        input  frame_done,
        input  underrun_cnt
    );
endinterface

// File: rtl/frame_serializer.sv
// Serialises payload bytes into framed 10-bit words: SYNC_LEN ones, WORDS_PER_FRAME data
// words {byte,2'b00} MSB first, then GAP_LEN zeros. A one-byte hold register buffers the producer.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | DOUT=0, waiting for a held byte to start a frame
// SYNC  | DOUT=1 for SYNC_LEN cycles; first word loads on the last one
// DATA  | shifting words out MSB first, next word loads after bit 0
// GAP   | DOUT=0 for GAP_LEN cycles; FRAME_DONE pulses on the first
module frame_serializer #(
    parameter int unsigned WORDS_PER_FRAME = 90,
    parameter int unsigned SYNC_LEN        = 10,
    parameter int unsigned GAP_LEN         = 4
) (
    input  logic                  clk_30mhz_i,
    input  logic                  rst_i,
    frame_serializer_if.slave     bus
);

    localparam int unsigned PH_MAX_SG = (SYNC_LEN > GAP_LEN) ? SYNC_LEN : GAP_LEN;
    localparam int unsigned PH_MAX    = (PH_MAX_SG > 10) ? PH_MAX_SG : 10;
    localparam int unsigned PH_W      = $clog2(PH_MAX + 1);
    localparam int unsigned WD_W      = $clog2(WORDS_PER_FRAME + 1);

    localparam logic [PH_W-1:0] SYNC_LAST = PH_W'(SYNC_LEN - 1);
    localparam logic [PH_W-1:0] BIT_LAST  = PH_W'(9);
    localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(GAP_LEN - 1);
    localparam logic [WD_W-1:0] WORD_LAST = WD_W'(WORDS_PER_FRAME - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [WD_W-1:0] word_q,  word_d;
    // Bit 9 of each word goes straight to dout_q at load, so only the remaining 9 bits are kept.
    logic [8:0]      shift_q, shift_d;
    logic            dout_q,  dout_d;
    logic            done_q,  done_d;
    logic [7:0]      under_q, under_d;
    logic [7:0]      hold_q,  hold_d;
    logic            hold_full_q, hold_full_d;
    logic            ready_q, ready_d;

    logic            xfer;
    logic            load;
    logic            start_frame;
    logic [9:0]      word_next;

    assign xfer = bus.din_valid & ready_q;

    always_ff @(posedge clk_30mhz_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            word_q      <= '0;
            shift_q     <= '0;
            dout_q      <= 1'b0;
            done_q      <= 1'b0;
            under_q     <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            word_q      <= word_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            done_q      <= done_d;
            under_q     <= under_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        word_d      = word_q;
        shift_d     = shift_q;
        dout_d      = 1'b0;
        done_d      = 1'b0;
        under_d     = under_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        start_frame = 1'b0;
        load        = 1'b0;
        word_next   = 10'd0;

        case (state_q)
            ST_IDLE: begin
                start_frame = hold_full_q;
            end
            ST_SYNC: begin
                dout_d = 1'b1;
                if (phase_q == SYNC_LAST) begin
                    load    = 1'b1;
                    state_d = ST_DATA;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_DATA: begin
                if (phase_q == BIT_LAST) begin
                    phase_d = '0;
                    if (word_q == WORD_LAST) begin
                        state_d = ST_GAP;
                        done_d  = 1'b1;
                    end else begin
                        load   = 1'b1;
                        word_d = word_q + WD_W'(1);
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                    shift_d = {shift_q[7:0], 1'b0};
                    dout_d  = shift_q[8];
                end
            end
            ST_GAP: begin
                if (phase_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                    // Leaving the gap with a byte waiting starts the next frame with no idle bit.
                    start_frame = hold_full_q;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_frame) begin
            state_d = ST_SYNC;
            phase_d = '0;
            word_d  = '0;
            dout_d  = 1'b1;
            under_d = 8'd0;
        end

        if (load) begin
            if (hold_full_q) begin
                word_next   = {hold_q, 2'b00};
                hold_full_d = 1'b0;
            end else begin
                word_next = 10'd0;
                if (under_q != 8'hFF) begin
                    under_d = under_q + 8'd1;
                end
            end
            shift_d = word_next[8:0];
            dout_d  = word_next[9];
        end

        if (xfer) begin
            hold_full_d = 1'b1;
            hold_d      = bus.din_byte;
        end
    end

    assign ready_d = ~hold_full_d;

    assign bus.din_ready    = ready_q;
    assign bus.dout         = dout_q;
    assign bus.frame_active = (state_q == ST_SYNC) || (state_q == ST_DATA);
    assign bus.frame_done   = done_q;
    assign bus.underrun_cnt = under_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: streams byte patterns, captures DOUT per cycle and
// compares against frames rebuilt from the byte list and the frame timing.
`timescale 1ns/1ps
module tb_frame_serializer;

    localparam int WPF   = 90;
    localparam int SYNC  = 10;
    localparam int GAP   = 4;
    localparam int FRAME = SYNC + 10 * WPF;

    logic clk = 1'b0;
    logic rst;

    always #16 clk = ~clk;

    frame_serializer_if bus();

    frame_serializer #(
        .WORDS_PER_FRAME(WPF),
        .SYNC_LEN       (SYNC),
        .GAP_LEN        (GAP)
    ) dut (
        .clk_30mhz_i(clk),
        .rst_i      (rst),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;
    int accepted;

    logic [7:0] src [0:255];
    logic       cap     [$];
    logic       cap_fa  [$];
    logic       cap_fd  [$];
    logic       cap_rdy [$];
    logic [7:0] cap_un  [$];
    logic       expq    [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One loop pass = one rising edge; index i holds the outputs right after edge i.
    task automatic stream(input int n, input bit throttle, input int ncyc);
        int sent;
        bit pend;
        bit rdy;
        sent = 0;
        pend = 1'b0;
        cap.delete(); cap_fa.delete(); cap_fd.delete(); cap_rdy.delete(); cap_un.delete();
        for (int i = 0; i < ncyc; i++) begin
            if (throttle) begin
                if (!pend && sent < n && (i % 10) == 0) pend = 1'b1;
            end else begin
                pend = (sent < n);
            end
            bus.din_valid = pend;
            bus.din_byte  = pend ? src[sent] : 8'h00;
            rdy = bus.din_ready;
            @(posedge clk);
            @(negedge clk);
            if (pend && rdy) begin
                sent++;
                pend = 1'b0;
            end
            cap.push_back(bus.dout);
            cap_fa.push_back(bus.frame_active);
            cap_fd.push_back(bus.frame_done);
            cap_rdy.push_back(bus.din_ready);
            cap_un.push_back(bus.underrun_cnt);
        end
        bus.din_valid = 1'b0;
        bus.din_byte  = 8'h00;
        accepted = sent;
    endtask

    task automatic exp_frame(input int first, input int nb);
        logic [9:0] w;
        for (int s = 0; s < SYNC; s++) expq.push_back(1'b1);
        for (int k = 0; k < WPF; k++) begin
            w = (k < nb) ? {src[first + k], 2'b00} : 10'h000;
            for (int b = 9; b >= 0; b--) expq.push_back(w[b]);
        end
        for (int g = 0; g < GAP; g++) expq.push_back(1'b0);
    endtask

    task automatic build_exp(input int n);
        expq.delete();
        expq.push_back(1'b0);
        exp_frame(0, (n < WPF) ? n : WPF);
        if (n > WPF) exp_frame(WPF, n - WPF);
    endtask

    task automatic cmp_stream(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < cap.size() && i < expq.size(); i++) begin
            if (cap[i] !== expq[i]) bad++;
        end
        check(tag, bad, 0);
    endtask

    function automatic logic [9:0] word_at(input int base);
        logic [9:0] w;
        for (int j = 0; j < 10; j++) w[9 - j] = cap[base + j];
        return w;
    endfunction

    function automatic int count_fd();
        int c;
        c = 0;
        for (int i = 0; i < cap_fd.size(); i++) if (cap_fd[i] === 1'b1) c++;
        return c;
    endfunction

    initial begin
        int run;
        int longest;
        int low;
        int maxlow;

        bus.din_valid = 1'b0;
        bus.din_byte  = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dout",     bus.dout,         1'b0);
        check("rst_active",   bus.frame_active, 1'b0);
        check("rst_done",     bus.frame_done,   1'b0);
        check("rst_underrun", bus.underrun_cnt, 8'd0);
        check("rst_ready",    bus.din_ready,    1'b0);
        rst = 1'b0;
        #1;
        check("ready_before_first_edge", bus.din_ready, 1'b0);
        @(negedge clk);
        check("ready_first_edge", bus.din_ready, 1'b1);
        repeat (2) @(negedge clk);

        // Back-to-back 1..90
        for (int k = 0; k < WPF; k++) src[k] = 8'(k + 1);
        stream(WPF, 1'b0, FRAME + GAP + 4);
        build_exp(WPF);
        cmp_stream("b2b_stream");
        check("b2b_word0",      word_at(SYNC + 1), 10'h004);
        check("b2b_word89",     word_at(SYNC + 1 + 890), 10'h168);
        check("b2b_done_911",   cap_fd[911], 1'b1);
        check("b2b_done_count", count_fd(), 1);
        check("b2b_active_0",   cap_fa[0],   1'b0);
        check("b2b_active_1",   cap_fa[1],   1'b1);
        check("b2b_active_910", cap_fa[910], 1'b1);
        check("b2b_active_911", cap_fa[911], 1'b0);
        check("b2b_underrun",   cap_un[917], 8'd0);
        check("b2b_accepted",   accepted, WPF);
        check("b2b_idle_dout",  cap[917], 1'b0);

        // Starvation: one byte only
        src[0] = 8'hA5;
        stream(1, 1'b0, FRAME + GAP + 4);
        build_exp(1);
        cmp_stream("starve_stream");
        check("starve_word0",      word_at(SYNC + 1), 10'h294);
        check("starve_under_20",   cap_un[20], 8'd0);
        check("starve_under_21",   cap_un[21], 8'd1);
        check("starve_underrun",   cap_un[917], 8'd89);
        check("starve_idle_active", cap_fa[917], 1'b0);
        check("starve_idle_dout",  cap[917], 1'b0);

        // 0xFF payload: no false sync
        for (int k = 0; k < WPF; k++) src[k] = 8'hFF;
        stream(WPF, 1'b0, FRAME + GAP + 4);
        build_exp(WPF);
        cmp_stream("ff_stream");
        check("ff_under_held", cap_un[0], 8'd89);
        check("ff_under_clear", cap_un[1], 8'd0);
        run = 0;
        longest = 0;
        for (int i = SYNC + 1; i <= FRAME; i++) begin
            run = (cap[i] === 1'b1) ? run + 1 : 0;
            if (run > longest) longest = run;
        end
        check("ff_longest_run", longest, 8);

        // Reset at word 40 bit 5 (index 11+400+4)
        for (int k = 0; k < WPF; k++) src[k] = 8'(k + 1);
        stream(WPF, 1'b0, SYNC + 1 + 400 + 5);
        build_exp(WPF);
        cmp_stream("pre_reset_stream");
        check("pre_reset_bit", cap[SYNC + 1 + 404], 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_dout",     bus.dout,         1'b0);
        check("midrst_active",   bus.frame_active, 1'b0);
        check("midrst_ready",    bus.din_ready,    1'b0);
        check("midrst_underrun", bus.underrun_cnt, 8'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready_pre", bus.din_ready, 1'b0);
        @(negedge clk);
        check("midrst_ready_first", bus.din_ready, 1'b1);
        repeat (4) @(negedge clk);
        check("midrst_idle_dout",   bus.dout,         1'b0);
        check("midrst_idle_active", bus.frame_active, 1'b0);
        src[0] = 8'h3C;
        stream(1, 1'b0, FRAME + GAP + 4);
        build_exp(1);
        cmp_stream("post_reset_stream");
        check("post_reset_word0", word_at(SYNC + 1), 10'h0F0);

        // Two consecutive frames, 180 bytes
        for (int k = 0; k < 2 * WPF; k++) src[k] = 8'(k + 1);
        stream(2 * WPF, 1'b0, 1 + 2 * (FRAME + GAP) + 3);
        build_exp(2 * WPF);
        cmp_stream("two_frame_stream");
        check("two_done_count", count_fd(), 2);
        check("two_done_first", cap_fd[911], 1'b1);
        check("two_done_second", cap_fd[911 + FRAME + GAP], 1'b1);
        run = 0;
        for (int i = FRAME + 1; i < FRAME + 1 + 10 && cap[i] === 1'b0; i++) run++;
        check("two_gap_zeros", run, GAP);
        check("two_accepted",  accepted, 2 * WPF);
        check("two_underrun",  cap_un[cap_un.size() - 1], 8'd0);

        // Throttled producer: valid raised every 10th cycle, held until taken
        for (int k = 0; k < WPF; k++) src[k] = 8'h5A ^ 8'(k);
        stream(WPF, 1'b1, FRAME + GAP + 4);
        build_exp(WPF);
        cmp_stream("throttle_stream");
        check("throttle_underrun", cap_un[917], 8'd0);
        check("throttle_accepted", accepted, WPF);
        low = 0;
        maxlow = 0;
        for (int i = SYNC + 1; i < cap_rdy.size(); i++) begin
            low = (cap_rdy[i] === 1'b0) ? low + 1 : 0;
            if (low > maxlow) maxlow = low;
        end
        check("throttle_ready_low_le10", (maxlow <= 10), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_serializer.md
FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 Parameter WORDS_PER_FRAME, default 90, is the number of 10-bit data words sent after each sync field.
REQ-002 Parameter SYNC_LEN, default 10, is the number of consecutive '1' bits in the frame start field.
REQ-003 Parameter GAP_LEN, default 4, is the number of '0' bits driven after each frame; it SHALL be at least 1.
REQ-004 CLK_30MHZ  in  1  Single clock; all state changes occur on its rising edge.
REQ-005 RST  in  1  Reset, asynchronous and active-high.
REQ-006 DIN_BYTE  in  8  Payload byte offered by the producer.
REQ-007 DIN_VALID  in  1  DIN_BYTE is valid this cycle.
REQ-008 DIN_READY  out  1  The block can accept a byte this cycle.
REQ-009 DOUT  out  1  Registered serial frame stream, MSB first.
REQ-010 FRAME_ACTIVE  out  1  High while the SYNC or DATA field is on DOUT.
REQ-011 FRAME_DONE  out  1  One-cycle pulse on the first GAP cycle.
REQ-012 UNDERRUN_CNT  out  8  Number of zero-fill words inserted in the current or last frame; saturates at 255.

Function
REQ-013 A byte transfer SHALL occur on a rising edge where DIN_VALID=1 and DIN_READY=1, writing DIN_BYTE into a one-byte hold register.
REQ-014 DIN_READY SHALL be a registered function of hold-register state: 1 when the hold register is empty, 0 when it is full; it SHALL NOT depend combinationally on DIN_VALID.
REQ-015 Each data word SHALL be {byte[7:0], 2'b00}, so no false sync run longer than 8 ones can appear.
REQ-016 The FSM SHALL have four states: IDLE, SYNC, DATA and GAP.
REQ-017 IDLE: DOUT=0; when the hold register is full at an edge, the next state SHALL be SYNC.
REQ-018 SYNC: DOUT=1 for exactly SYNC_LEN cycles; on the last SYNC cycle the first word SHALL be loaded into the 10-bit shift register.
REQ-019 DATA: DOUT=shift[9] each cycle, with a left shift per cycle; after bit 0 of a word, the next word SHALL load at the same edge, with no idle bit between words.
REQ-020 At each word load the hold byte SHALL be used if the hold register is full, and the hold register SHALL then be marked empty.
REQ-021 If the hold register is empty at a word load, a 0x00 word SHALL be sent instead, and UNDERRUN_CNT SHALL increment (saturating).
REQ-022 After WORDS_PER_FRAME words the FSM SHALL enter GAP and drive DOUT=0 for GAP_LEN cycles, then return to IDLE.
REQ-023 From IDLE, a new frame SHALL start only per REQ-017; pending data is never dropped.
REQ-024 UNDERRUN_CNT SHALL clear to 0 on the IDLE->SYNC transition and hold its value through GAP and IDLE.
REQ-025 Timing: if a byte is accepted at edge E0 while in IDLE, then:
- DOUT=1 SHALL hold from E1 through E(SYNC_LEN).
- Word k bit b SHALL appear from edge E(SYNC_LEN+1+10k+(9-b)).
- A frame SHALL occupy SYNC_LEN+10*WORDS_PER_FRAME cycles (910 at defaults).
REQ-026 Word and bit counters SHALL be wide enough for WORDS_PER_FRAME and SYNC_LEN without wrap before the terminal count, and SHALL reset to 0 at each frame start.
REQ-027 Transfer and word load cannot coincide, because a transfer needs an empty hold register and a load consumes a full one; a word load followed by a transfer on the next edge SHALL be supported.

Reset
REQ-028 While RST=1, and immediately when it asserts including mid-frame:
- DOUT=0, FRAME_ACTIVE=0, FRAME_DONE=0, UNDERRUN_CNT=0, DIN_READY=0.
- The FSM SHALL be in IDLE with the hold register empty; any held byte is discarded.
REQ-029 DIN_READY SHALL first go to 1 on the first edge after RST deasserts.

Verification
REQ-030 Back-to-back stream: feed bytes 1..90 with DIN_VALID held at 1 -> DOUT shows 10 ones, then words 0x004, 0x008, ..., 0x168 MSB first; FRAME_DONE pulses at cycle 911 after the first SYNC bit; UNDERRUN_CNT=0.
REQ-031 Starvation: feed 1 byte (0xA5) only -> word0=0x294, then 89 zero words; UNDERRUN_CNT=89; FSM returns to IDLE after the gap.
REQ-032 Sync-alias check: feed 90 bytes of 0xFF -> the longest run of ones on DOUT after the sync field is 8.
REQ-033 Reset mid-frame: assert RST at word 40 bit 5 -> DOUT=0 immediately; after release, DIN_READY=1 on the first edge and the next frame starts from a fresh SYNC.
REQ-034 Consecutive frames: feed 180 bytes continuously -> two frames separated by exactly GAP_LEN=4 zero bits, with no byte lost or duplicated.
REQ-035 Throttled producer: assert DIN_VALID every 10th cycle -> DIN_READY never stays low for more than 10 cycles, and UNDERRUN_CNT=0.
